// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit adder slice shared
// across WORDS words, least-significant word first, carry held in a register.
module adder_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                        state;
  logic [IDXW-1:0]               idx;
  logic                          carry;
  logic                          sub_r;
  logic [WORDS-1:0][WIDTH-1:0]   a_r;
  logic [WORDS-1:0][WIDTH-1:0]   b_r;
  logic [WORDS-1:0][WIDTH-1:0]   sum_r;

  logic [WIDTH-1:0]              a_w;
  logic [WIDTH-1:0]              b_w;
  logic [WIDTH:0]                w;
  logic                          c_msb_in;
  logic                          last_word;

  // Word slice: operand B inverted for subtract, carry-in from the register.
  always_comb begin
    a_w       = a_r[idx];
    b_w       = b_r[idx] ^ {WIDTH{sub_r}};
    w         = (WIDTH+1)'(a_w) + (WIDTH+1)'(b_w) + (WIDTH+1)'(carry);
    c_msb_in  = w[WIDTH-1] ^ a_w[WIDTH-1] ^ b_w[WIDTH-1];
    last_word = (idx == IDXW'(WORDS - 1));
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign sum      = sum_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      sub_r     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            idx   <= '0;
            carry <= sub;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= w[WIDTH-1:0];
          carry      <= w[WIDTH];
          idx        <= idx + IDXW'(1);
          if (last_word) begin
            idx       <= '0;
            cout      <= w[WIDTH];
            ovf       <= c_msb_in ^ w[WIDTH];
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (WIDTH=8, WORDS=4) with hand-computed results.
module tb_adder_seq_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned TW    = WIDTH * WORDS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          cout;
  logic          ovf;
  logic          busy;

  int checks;
  int errors;

  adder_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, then wait (bounded) for out_valid; lat = edges after accept.
  task automatic run_op(input logic [TW-1:0] av, input logic [TW-1:0] bv,
                        input logic sv, input bit toggle, output int lat);
    a        = av;
    b        = bv;
    sub      = sv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (toggle) begin
        a   = TW'($urandom);
        b   = TW'($urandom);
        sub = ~sub;
      end
      step();
      lat++;
    end
  endtask

  int lat;
  logic [TW-1:0] held_sum;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Carry across a word boundary; also latency and single-cycle out_valid.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat);
    chk("add1_latency", 32'(lat), 32'd4);
    chk("add1_sum", sum, 32'h00000100);
    chk("add1_cout", 32'(cout), 32'h0);
    chk("add1_ovf", 32'(ovf), 32'h0);
    chk("add1_busy", 32'(busy), 32'h1);
    step();
    chk("add1_valid_drop", 32'(out_valid), 32'h0);
    chk("add1_idle_ready", 32'(in_ready), 32'h1);
    chk("add1_idle_busy", 32'(busy), 32'h0);

    run_op(32'h00000000, 32'h00000001, 1'b1, 1'b0, lat);
    chk("sub_latency", 32'(lat), 32'd4);
    chk("sub_sum", sum, 32'hFFFFFFFF);
    chk("sub_cout", 32'(cout), 32'h0);
    chk("sub_ovf", 32'(ovf), 32'h0);
    step();

    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    chk("ovf_sum", sum, 32'h80000000);
    chk("ovf_cout", 32'(cout), 32'h0);
    chk("ovf_ovf", 32'(ovf), 32'h1);
    step();

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    chk("wrap_sum", sum, 32'h00000000);
    chk("wrap_cout", 32'(cout), 32'h1);
    chk("wrap_ovf", 32'(ovf), 32'h0);
    step();

    // Back-pressure: result held, new request ignored while in HOLD.
    out_ready = 1'b0;
    run_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, lat);
    chk("bp_sum", sum, 32'h00000030);
    held_sum = sum;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a        = 32'h00001000;
        b        = 32'h00000001;
        sub      = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_sum", sum, held_sum);
      chk("bp_hold_cout", 32'(cout), 32'h0);
      chk("bp_hold_ovf", 32'(ovf), 32'h0);
      chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
    end
    a         = 32'h00001000;
    b         = 32'h00000001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("bp_exit_valid", 32'(out_valid), 32'h0);
    chk("bp_exit_in_ready", 32'(in_ready), 32'h1);
    chk("bp_exit_busy", 32'(busy), 32'h0);
    run_op(32'h00001000, 32'h00000001, 1'b0, 1'b0, lat);
    chk("bp_new_latency", 32'(lat), 32'd4);
    chk("bp_new_sum", sum, 32'h00001001);
    step();

    // Operands scrambled every cycle after capture must not matter.
    run_op(32'h00000050, 32'h00000020, 1'b1, 1'b1, lat);
    chk("tog_latency", 32'(lat), 32'd4);
    chk("tog_sum", sum, 32'h00000030);
    chk("tog_cout", 32'(cout), 32'h1);
    chk("tog_ovf", 32'(ovf), 32'h0);
    step();

    // Asynchronous abort after two RUN edges.
    a        = 32'h0F0F0F0F;
    b        = 32'h01010101;
    sub      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort_pre_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 32'h0);
    chk("abort_cout", 32'(cout), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_sum", sum, 32'h23456789);
    chk("post_rst_cout", 32'(cout), 32'h0);
    chk("post_rst_ovf", 32'(ovf), 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
